// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MDU controller: op codes, FSM states, default latencies.
// Build option: define MDU_MADD_EN to decode MADD/MADDU/MSUB/MSUBU as mult-class ops.
package mdu_ctrl_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Reserved codes and (without MDU_MADD_EN) the madd family fall through to "not an MDU op".
    function automatic logic is_mult_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Handshake/data bundle between the E stage and the MDU controller.
interface mdu_ctrl_if;
    logic        op_en;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output op_en, op, rs_val, rt_val,
        input  start, busy, rd_data, hi_out, lo_out
    );

    modport slave (
        input  op_en, op, rs_val, rt_val,
        output start, busy, rd_data, hi_out, lo_out
    );
endinterface

// File: rtl/mdu_ctrl_calc.sv
// Combinational multiply/divide/madd arithmetic producing the 64-bit {HI,LO} result.
// Build option: MDU_MADD_EN enables the accumulate/subtract forms.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] rs_s64, rt_s64, prod_s, prod_u;
    logic [31:0] abs_rs, abs_rt, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        div_zero;

    assign rs_s64 = {{32{rs_val[31]}}, rs_val};
    assign rt_s64 = {{32{rt_val[31]}}, rt_val};
    assign prod_s = rs_s64 * rt_s64;
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
    assign div_zero = (rt_val == 32'd0);
    assign abs_rs   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign abs_rt   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    assign q_mag    = div_zero ? 32'd0 : abs_rs / abs_rt;
    assign r_mag    = div_zero ? 32'd0 : abs_rs % abs_rt;
    assign q_s      = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s      = rs_val[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u      = div_zero ? 32'd0 : rs_val / rt_val;
    assign r_u      = div_zero ? 32'd0 : rs_val % rt_val;

    always_comb begin
        result = {hi, lo};
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   if (!div_zero) result = {r_s, q_s};
            OP_DIVU:  if (!div_zero) result = {r_u, q_u};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MADDU: result = {hi, lo} + prod_u;
            OP_MSUB:  result = {hi, lo} - prod_s;
            OP_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO and sequences fixed-latency mult/div ops through IDLE/BUSY.
// Build option: MDU_MADD_EN (see mdu_ctrl_pkg) adds the madd family as mult-class ops.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    state_e      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi, hi_nxt, lo, lo_nxt;
    logic [63:0] pending, pending_nxt, calc_result;
    logic        is_mult, is_div;

    mdu_calc u_calc (
        .op     (bus.op),
        .rs_val (bus.rs_val),
        .rt_val (bus.rt_val),
        .hi     (hi),
        .lo     (lo),
        .result (calc_result)
    );

    assign is_mult     = is_mult_op(bus.op);
    assign is_div      = is_div_op(bus.op);
    assign bus.start   = bus.op_en & (is_mult | is_div) & (state == IDLE);
    assign bus.busy    = (state == BUSY);
    assign bus.hi_out  = hi;
    assign bus.lo_out  = lo;
    assign bus.rd_data = !bus.op_en          ? 32'd0 :
                         (bus.op == OP_MFHI) ? hi    :
                         (bus.op == OP_MFLO) ? lo    : 32'd0;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    pending_nxt = calc_result;
                    cnt_nxt     = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_nxt   = BUSY;
                end else if (bus.op_en && bus.op == OP_MTHI) begin
                    hi_nxt = bus.rs_val;
                end else if (bus.op_en && bus.op == OP_MTLO) begin
                    lo_nxt = bus.rs_val;
                end
            end
            BUSY: begin
                // Writes arriving while busy are dropped; only the countdown advances.
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi_nxt    = pending[63:32];
                    lo_nxt    = pending[31:0];
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pending <= 64'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt);
        bus.op_en  = en;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO; returns busy length.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, output int lat);
        longint      s_rs, s_rt, sq, sr;
        logic [63:0] acc, pu, ps;
        s_rs = longint'($signed(rs));
        s_rt = longint'($signed(rt));
        ps   = 64'(s_rs * s_rt);
        pu   = {32'd0, rs} * {32'd0, rt};
        acc  = {m_hi, m_lo};
        lat  = 0;
        case (op)
            OP_MULT:  begin acc = ps; lat = MC; end
            OP_MULTU: begin acc = pu; lat = MC; end
            OP_DIV: begin
                lat = DC;
                if (rt != 0) begin
                    sq  = s_rs / s_rt;
                    sr  = s_rs % s_rt;
                    acc = {sr[31:0], sq[31:0]};
                end
            end
            OP_DIVU: begin
                lat = DC;
                if (rt != 0) acc = {rs % rt, rs / rt};
            end
            OP_MTHI: acc[63:32] = rs;
            OP_MTLO: acc[31:0]  = rs;
`ifdef MDU_MADD_EN
            OP_MADD:  begin acc = acc + ps; lat = MC; end
            OP_MADDU: begin acc = acc + pu; lat = MC; end
            OP_MSUB:  begin acc = acc - ps; lat = MC; end
            OP_MSUBU: begin acc = acc - pu; lat = MC; end
`endif
            default: lat = 0;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
    endtask

    // Issue one op from IDLE, measure how long busy stays high; returns the measured length.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic exp_start, output int busy_len);
        applyStimulus(1'b1, op, rs, rt);
        #1;
        checkOutput({name, " start"}, 32'(bus.start), 32'(exp_start));
        tick();
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        busy_len = 0;
        while (bus.busy === 1'b1 && busy_len < 40) begin
            busy_len++;
            tick();
        end
    endtask

    initial begin
        int          lat, blen;
        logic [31:0] old_hi, old_lo;
        logic        saw_busy;

        vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[4]  = '{OP_MTHI,  32'hA,        32'h0,        32'h0000000A, 32'hFFFFFFFD, 0};
        vecs[5]  = '{OP_MTLO,  32'hB,        32'h0,        32'h0000000A, 32'h0000000B, 0};
        vecs[6]  = '{OP_DIV,   32'h5,        32'h0,        32'h0000000A, 32'h0000000B, DC};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[9]  = '{4'd13,    32'h55,       32'h66,       32'hFFFFFFFE, 32'h00000001, 0};
        vecs[10] = '{OP_MTHI,  32'h0,        32'h0,        32'h00000000, 32'h00000001, 0};
        vecs[11] = '{OP_MTLO,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MDU_MADD_EN
        vecs[12] = '{OP_MADDU, 32'h1,        32'h1,        32'h00000001, 32'h00000000, MC};
`else
        vecs[12] = '{OP_MADDU, 32'h1,        32'h1,        32'h00000000, 32'hFFFFFFFF, 0};
`endif

        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset hi", bus.hi_out, 32'd0);
        checkOutput("reset lo", bus.lo_out, 32'd0);
        checkOutput("reset rd_data", bus.rd_data, 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_lat != 0, blen);
            checkOutput($sformatf("vec%0d busy_len", i), 32'(blen), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d hi", i), bus.hi_out, vecs[i].exp_hi);
            checkOutput($sformatf("vec%0d lo", i), bus.lo_out, vecs[i].exp_lo);
            applyStimulus(1'b1, OP_MFHI, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("vec%0d mfhi", i), bus.rd_data, vecs[i].exp_hi);
            applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("vec%0d mflo", i), bus.rd_data, vecs[i].exp_lo);
            applyStimulus(1'b0, OP_MFLO, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("vec%0d rd_data idle", i), bus.rd_data, 32'd0);
            tick();
        end
        m_hi = vecs[12].exp_hi;
        m_lo = vecs[12].exp_lo;

        // MFLO while busy sees the old LO; MTHI and a second MULT while busy are dropped.
        old_hi = m_hi;
        old_lo = m_lo;
        applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1;
        checkOutput("mflo during busy", bus.rd_data, old_lo);
        applyStimulus(1'b1, OP_MULT, 32'd7, 32'd7);
        #1;
        checkOutput("start while busy", 32'(bus.start), 32'd0);
        tick();
        applyStimulus(1'b1, OP_MTHI, 32'hDEAD, 32'd0);
        tick();
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("hi held during busy", bus.hi_out, old_hi);
        blen = 2;
        while (bus.busy === 1'b1 && blen < 40) begin
            blen++;
            tick();
        end
        checkOutput("busy_len with ignored ops", 32'(blen), 32'(MC));
        checkOutput("mult after ignored hi", bus.hi_out, 32'd0);
        checkOutput("mult after ignored lo", bus.lo_out, 32'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;

        // Reset in the third busy cycle cancels the commit.
        applyStimulus(1'b1, OP_MULT, 32'h1000, 32'h1000);
        tick();
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("busy after mid reset", 32'(bus.busy), 32'd0);
        checkOutput("hi after mid reset", bus.hi_out, 32'd0);
        checkOutput("lo after mid reset", bus.lo_out, 32'd0);
        saw_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.busy !== 1'b0) saw_busy = 1'b1;
            tick();
        end
        checkOutput("no busy after reset", 32'(saw_busy), 32'd0);
        checkOutput("no late commit lo", bus.lo_out, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  rop;
            logic [31:0] rs, rt;
            rop = 4'($urandom_range(0, 15));
            rs  = $urandom;
            rt  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            model_apply(rop, rs, rt, lat);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, rs, rt, lat != 0, blen);
            checkOutput($sformatf("rnd%0d busy_len", i), 32'(blen), 32'(lat));
            checkOutput($sformatf("rnd%0d hi", i), bus.hi_out, m_hi);
            checkOutput($sformatf("rnd%0d lo", i), bus.lo_out, m_lo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline. Accepts mult/div class ops and mthi/mtlo/mfhi/mflo, and sequences fixed-latency mult/div operations through an IDLE/BUSY state machine. Owns the HI/LO registers. Exports `start` and `busy` to the hazard control unit so it can stall MDU-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd-family when enabled); legal 1..15
- DIV_CYCLES, 10, busy duration for div/divu; legal 1..15

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- op_en  input  1  E-stage instruction is an MDU-class op this cycle
- op  input  4  MDU op code (encoding in shared package)
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- start  output  1  combinational: op_en & op is mult/div class & !busy
- busy  output  1  registered: computation in flight
- rd_data  output  32  combinational: HI for MFHI, LO for MFLO, else 0
- hi_out  output  32  current HI register
- lo_out  output  32  current LO register

Behaviour:
- Op codes:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8
  - MADD=9, MADDU=10, MSUB=11, MSUBU=12
  - 13..15 are reserved and treated as NONE.
- Reset (reset==0 at a clk edge): state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending result=0. Reset mid-BUSY cancels the op; no HI/LO commit.
- FSM state IDLE:
  - On `start` at edge T: capture the computed 64-bit result into the pending register, load cnt with MULT_CYCLES or DIV_CYCLES, go to BUSY. busy=1 from T+1.
  - On op_en with MTHI at an edge: HI<=rs_val in the same edge; no busy.
  - On op_en with MTLO at an edge: LO<=rs_val in the same edge; no busy.
- FSM state BUSY:
  - cnt decrements every edge.
  - At the edge where cnt==1: commit pending to HI/LO, go to IDLE, busy=0.
  - busy is therefore high for exactly N cycles. The new HI/LO are visible in the first cycle after busy falls.
- Ops while busy: MTHI, MTLO and mult/div ops are ignored (no state change). The hazard control unit guarantees these never arrive; the bench asserts this. MFHI/MFLO while busy return the old committed values.
- Arithmetic:
  - MULT: signed 32x32→64, HI=upper, LO=lower. MULTU: unsigned.
  - DIV: LO=signed quotient, HI=signed remainder (remainder sign follows the dividend). DIVU: unsigned.
  - Divide by zero: HI/LO unchanged after commit (pending loaded with current HI/LO); busy still lasts DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start and a same-cycle MFHI/MFLO cannot coexist (single op per cycle).
- op_en=0: outputs rd_data=0; no state change except the BUSY countdown.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are decoded as mult-class, with latency MULT_CYCLES. The pending value is {HI,LO} ± product (signed/unsigned per op), computed from the HI/LO values at start.
- Undefined: op codes 9..12 are treated as NONE: start=0, no state change.

Decomposition:
- Shared package/header mdu_defs:
  - 4-bit op code constants (all 13)
  - state encodings IDLE=0, BUSY=1
  - default latency constants
- Sub-module mdu_calc: purely combinational. Inputs op, rs_val, rt_val, hi, lo; output 64-bit result. It isolates the multiply/divide/divide-by-zero/madd arithmetic from the sequencing FSM.

Test Plan:
1. Reset low 2 cycles, then MTHI rs=0x12345678 → hi_out=0x12345678 next cycle; lo_out=0; busy never asserts.
2. MULT rs=0xFFFFFFFE, rt=3 at edge T → busy high T+1..T+5, low at T+6; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6. MFLO during busy returns the old LO.
3. DIVU rs=100, rt=7 → busy for exactly 10 cycles, then LO=14, HI=2. DIV rs=-7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
4. DIV by zero with prior HI=0xA, LO=0xB → busy 10 cycles, HI=0xA, LO=0xB afterwards. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
5. MULT started, reset pulled low at the 3rd busy cycle → next cycle busy=0, HI=LO=0, no later commit. Also: start driven high while busy → `start` output stays 0 and the result is unchanged.
6. (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF; MADDU rs=1, rt=1 → after 5 cycles HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged and busy stays 0.
